// File: rtl/freq_trim_seq.sv
// Oscillator trim campaign sequencer: walks N_OSC channels through the SAR frequency
// trimmer, capturing each channel's trim result or flagging a timeout.
module freq_trim_seq #(
  parameter int N_OSC  = 6,
  parameter int TW     = 16,
  parameter int TOW    = 20,
  parameter int SETTLE = 8
) (
  input  logic                rclk,
  input  logic                rstb,
  input  logic                start,
  input  logic                abort,
  input  logic [4*N_OSC-1:0]  msb_cfg,
  input  logic [TW*N_OSC-1:0] odiv_cfg,
  input  logic [TOW-1:0]      timeout_cyc,
  input  logic                trim_done,
  input  logic [TW-1:0]       trim_val,
  output logic [2:0]          osc_sel,
  output logic [3:0]          trim_msb,
  output logic [TW-1:0]       trim_odiv,
  output logic                trim_setb,
  output logic                busy,
  output logic                all_done,
  output logic                err,
  output logic [N_OSC-1:0]    res_valid,
  output logic [N_OSC-1:0]    res_to,
  input  logic [2:0]          rd_idx,
  output logic [TW-1:0]       rd_trim
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_TOUT = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam int             SCW         = $clog2(SETTLE);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [2:0]     IDX_LAST    = 3'(N_OSC - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [TOW-1:0]   tcnt_q, tcnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       msb_q, msb_d;
  logic [TW-1:0]    odiv_q, odiv_d;
  logic             setb_q, setb_d;
  logic             busy_q, busy_d;
  logic             all_done_q, all_done_d;
  logic             err_q, err_d;
  logic [N_OSC-1:0] valid_q, valid_d;
  logic [N_OSC-1:0] to_q, to_d;
  logic [TW-1:0]    res_trim_q [N_OSC];

  logic             done_meta_q, done_s_q, done_r_q, done_rise;
  logic             load_en, cap_en;
  logic [2:0]       load_idx;

  // trim_done comes from the oclk domain; only its synchronised rising edge is trusted.
  always_ff @(posedge rclk or negedge rstb) begin
    if (!rstb) begin
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      done_r_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the three flops a real shift chain;
      // blocking ones would collapse it into a single stage.
      done_meta_q <= trim_done;
      done_s_q    <= done_meta_q;
      done_r_q    <= done_s_q;
    end
  end

  assign done_rise = done_s_q & ~done_r_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    scnt_d     = scnt_q;
    tcnt_d     = tcnt_q;
    sel_d      = sel_q;
    msb_d      = msb_q;
    odiv_d     = odiv_q;
    setb_d     = setb_q;
    busy_d     = busy_q;
    all_done_d = all_done_q;
    err_d      = err_q;
    valid_d    = valid_q;
    to_d       = to_q;
    load_en    = 1'b0;
    load_idx   = idx_q;
    cap_en     = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      setb_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          idx_d      = 3'd0;
          valid_d    = '0;
          to_d       = '0;
          err_d      = 1'b0;
          all_done_d = 1'b0;
          busy_d     = 1'b1;
          load_en    = 1'b1;
          load_idx   = 3'd0;
        end
        S_LOAD: begin
          sel_d  = idx_q;
          msb_d  = msb_cfg[4*idx_q +: 4];
          odiv_d = odiv_cfg[TW*idx_q +: TW];
          if (scnt_q == '0) begin
            state_d = S_RUN;
            setb_d  = 1'b1;
            tcnt_d  = timeout_cyc;
          end else begin
            scnt_d = scnt_q - 1'b1;
          end
        end
        // A done already high on entry never produces done_rise, so it is ignored.
        S_RUN: begin
          if (done_rise)          state_d = S_CAPT;
          else if (tcnt_q == '0)  state_d = S_TOUT;
          else                    tcnt_d  = tcnt_q - 1'b1;
        end
        S_CAPT: begin
          cap_en         = 1'b1;
          valid_d[idx_q] = 1'b1;
          setb_d         = 1'b0;
          state_d        = S_NEXT;
        end
        S_TOUT: begin
          to_d[idx_q] = 1'b1;
          err_d       = 1'b1;
          setb_d      = 1'b0;
          state_d     = S_NEXT;
        end
        S_NEXT: begin
          setb_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = S_FIN;
          end else begin
            idx_d    = idx_q + 3'd1;
            load_en  = 1'b1;
            load_idx = idx_q + 3'd1;
          end
        end
        S_FIN: begin
          busy_d     = 1'b0;
          all_done_d = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (load_en) begin
        state_d = S_LOAD;
        scnt_d  = SETTLE_LAST;
        setb_d  = 1'b0;
        sel_d   = load_idx;
        msb_d   = msb_cfg[4*load_idx +: 4];
        odiv_d  = odiv_cfg[TW*load_idx +: TW];
      end
    end
  end

  always_ff @(posedge rclk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      scnt_q     <= '0;
      tcnt_q     <= '0;
      sel_q      <= 3'd0;
      msb_q      <= 4'd0;
      odiv_q     <= '0;
      setb_q     <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      scnt_q     <= scnt_d;
      tcnt_q     <= tcnt_d;
      sel_q      <= sel_d;
      msb_q      <= msb_d;
      odiv_q     <= odiv_d;
      setb_q     <= setb_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      to_q       <= to_d;
    end
  end

  // trim_val is sampled two cycles after done_s rises, so it is stable by CAPT.
  always_ff @(posedge rclk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: the result array is reset because it is only N_OSC words and rd_trim
      // must read 0 before a capture; larger storage would normally stay unreset.
      for (int i = 0; i < N_OSC; i++) res_trim_q[i] <= '0;
    end else if (cap_en) begin
      res_trim_q[idx_q] <= trim_val;
    end
  end

  always_comb begin
    rd_trim = '0;
    if (int'(rd_idx) < N_OSC) rd_trim = res_trim_q[rd_idx];
  end

  assign osc_sel   = sel_q;
  assign trim_msb  = msb_q;
  assign trim_odiv = odiv_q;
  assign trim_setb = setb_q;
  assign busy      = busy_q;
  assign all_done  = all_done_q;
  assign err       = err_q;
  assign res_valid = valid_q;
  assign res_to    = to_q;

endmodule
